// File: rtl/mul_job_controller.sv
// Host-side job sequencer for a memory-mapped 64x64 multiplier slave: loads operands, starts the
// operation, waits for the interrupt (bounded by TIMEOUT), reads the 128-bit product and clears it.
module mul_job_controller #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_a,
  input  logic [63:0]   req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [127:0]  rsp_result,
  output logic          rsp_err,
  output logic          M_sel,
  output logic          M_wr,
  output logic [7:0]    M_address,
  output logic [31:0]   M_dout,
  input  logic [31:0]   M_din,
  input  logic          m_interrupt
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [7:0] AddrStart = 8'h04;
  localparam logic [7:0] AddrClear = 8'h05;
  localparam logic [7:0] AddrRes0  = 8'h07;

  typedef enum logic [2:0] {
    StIdle, StWr, StStart, StWait, StRd, StClr, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [63:0]    a_q, a_d, b_q, b_d;
  logic [127:0]   result_q, result_d;

  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           m_sel_q, m_sel_d;
  logic           m_wr_q, m_wr_d;
  logic [7:0]     m_addr_q, m_addr_d;
  logic [31:0]    m_dout_q, m_dout_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d      = req_a;
          b_d      = req_b;
          idx_d    = 2'd0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = StWr;
        end
      end
      StWr: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StStart;
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (m_interrupt) begin
          idx_d   = 2'd0;
          state_d = StRd;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StClr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRd: begin
        // M_din is combinational on the registered address, so it is valid for this edge.
        result_d[{idx_q, 5'b0} +: 32] = M_din;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = StClr;
      end
      StClr: begin
        state_d = StDone;
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, giving Moore timing without glitches.
  always_comb begin
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    m_sel_d     = 1'b0;
    m_wr_d      = 1'b0;
    m_addr_d    = 8'h00;
    m_dout_d    = 32'h0;
    unique case (state_d)
      StIdle: req_ready_d = 1'b1;
      StWr: begin
        m_sel_d  = 1'b1;
        m_wr_d   = 1'b1;
        m_addr_d = {6'b0, idx_d};
        unique case (idx_d)
          2'd0: m_dout_d = a_d[31:0];
          2'd1: m_dout_d = a_d[63:32];
          2'd2: m_dout_d = b_d[31:0];
          2'd3: m_dout_d = b_d[63:32];
          default: m_dout_d = 32'h0;
        endcase
      end
      StStart: begin
        m_sel_d  = 1'b1;
        m_wr_d   = 1'b1;
        m_addr_d = AddrStart;
        m_dout_d = 32'h1;
      end
      StRd: begin
        m_sel_d  = 1'b1;
        m_addr_d = AddrRes0 + {6'b0, idx_d};
      end
      StClr: begin
        m_sel_d  = 1'b1;
        m_wr_d   = 1'b1;
        m_addr_d = AddrClear;
        m_dout_d = 32'h1;
      end
      StDone: rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      m_sel_q     <= 1'b0;
      m_wr_q      <= 1'b0;
      m_addr_q    <= 8'h00;
      m_dout_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      m_sel_q     <= m_sel_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_dout_q    <= m_dout_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign M_sel      = m_sel_q;
  assign M_wr       = m_wr_q;
  assign M_address  = m_addr_q;
  assign M_dout     = m_dout_q;

endmodule

// File: tb/tb_mul_job_controller.sv
// Directed bench for mul_job_controller with a behavioural multiplier slave (TIMEOUT=8).
module tb_mul_job_controller;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [63:0]   req_a, req_b;
  logic          rsp_valid, rsp_ready;
  logic [127:0]  rsp_result;
  logic          rsp_err;
  logic          M_sel, M_wr;
  logic [7:0]    M_address;
  logic [31:0]   M_dout, M_din;
  logic          m_interrupt;

  mul_job_controller #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .M_sel      (M_sel),
    .M_wr       (M_wr),
    .M_address  (M_address),
    .M_dout     (M_dout),
    .M_din      (M_din),
    .m_interrupt(m_interrupt)
  );

  always #5 clk = ~clk;

  // Slave model and bus log
  int           slave_delay = 0;
  bit           slave_mute = 1'b0;
  bit           stray_irq = 1'b0;
  logic [63:0]  slv_a = '0, slv_b = '0;
  logic [127:0] slv_prod = '0;
  logic         slv_busy = 1'b0;
  int           slv_cnt = 0;
  logic [7:0]   wr_addr [256];
  logic [31:0]  wr_data [256];
  logic [7:0]   rd_addr [256];
  int           wr_n = 0, rd_n = 0;

  always @(posedge clk) begin
    if (M_sel && M_wr) begin
      wr_addr[wr_n & 255] <= M_address;
      wr_data[wr_n & 255] <= M_dout;
      wr_n <= wr_n + 1;
      case (M_address)
        8'h00: slv_a[31:0]  <= M_dout;
        8'h01: slv_a[63:32] <= M_dout;
        8'h02: slv_b[31:0]  <= M_dout;
        8'h03: slv_b[63:32] <= M_dout;
        8'h04: if (M_dout[0]) begin
          slv_prod <= {64'b0, slv_a} * {64'b0, slv_b};
          slv_busy <= 1'b1;
          slv_cnt  <= slave_delay;
        end
        8'h05: if (M_dout[0]) slv_busy <= 1'b0;
        default: ;
      endcase
    end else begin
      if (M_sel) begin
        rd_addr[rd_n & 255] <= M_address;
        rd_n <= rd_n + 1;
      end
      if (slv_busy && slv_cnt > 0) slv_cnt <= slv_cnt - 1;
    end
  end

  always_comb begin
    M_din = 32'h0;
    if (M_sel && !M_wr) begin
      case (M_address)
        8'h07: M_din = slv_prod[31:0];
        8'h08: M_din = slv_prod[63:32];
        8'h09: M_din = slv_prod[95:64];
        8'h0A: M_din = slv_prod[127:96];
        default: M_din = 32'h0;
      endcase
    end
  end

  assign m_interrupt = (slv_busy && slv_cnt == 0 && !slave_mute) || stray_irq;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp;
    int           delay;
    int           stall;
    bit           stray;
    bit           mute;
  } vec_t;

  vec_t vecs[6];

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_bus"}, {M_sel, M_wr, M_address, M_dout}, 42'h0);
    chk({tag, "_hs"}, {req_ready, rsp_valid, rsp_err}, 3'b100);
  endtask

  task automatic run_job(input vec_t v);
    int n;
    int wb;
    int rb;
    int exp_lat;
    logic [31:0] ed;
    wb = wr_n;
    rb = rd_n;
    slave_delay = v.delay;
    slave_mute = v.mute;
    exp_lat = v.mute ? 14 : 11 + v.delay;
    req_a = v.a;
    req_b = v.b;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    chk("accept_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = ~v.a;
    req_b = ~v.b;
    if (v.stray) stray_irq = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (n == 4) stray_irq = 1'b0;
      if (n == 5) chk("wait_bus_idle", {M_sel, M_wr}, 2'b00);
      @(posedge clk); #1;
      n++;
    end
    stray_irq = 1'b0;
    chk("latency", n, exp_lat);
    chk("result", rsp_result, v.exp);
    chk("err", rsp_err, v.mute);
    chk("busy_ready", req_ready, 1'b0);
    req_valid = 1'b1;
    req_a = 64'h5555;
    req_b = 64'hAAAA;
    for (int i = 0; i < v.stall; i++) begin
      @(posedge clk); #1;
      chk("hold", {rsp_valid, req_ready, rsp_err, rsp_result}, {1'b1, 1'b0, v.mute, v.exp});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release", {req_ready, rsp_valid}, 2'b10);
    chk("wr_count", wr_n - wb, 6);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: ed = v.a[31:0];
        1: ed = v.a[63:32];
        2: ed = v.b[31:0];
        3: ed = v.b[63:32];
        default: ed = 32'h1;
      endcase
      chk("wr_seq", {wr_addr[(wb + i) & 255], wr_data[(wb + i) & 255]}, {8'(i), ed});
    end
    chk("rd_count", rd_n - rb, v.mute ? 0 : 4);
    if (!v.mute) begin
      for (int i = 0; i < 4; i++) chk("rd_seq", rd_addr[(rb + i) & 255], 8'h07 + 8'(i));
    end
  endtask

  initial begin
    int wb;
    vecs[0] = '{a: 64'h0000000100000002, b: 64'h0000000300000004,
                exp: 128'h00000000_00000003_0000000A_00000008,
                delay: 2, stall: 0, stray: 1'b0, mute: 1'b0};
    vecs[1] = '{a: 64'hFFFFFFFFFFFFFFFF, b: 64'hFFFFFFFFFFFFFFFF,
                exp: 128'hFFFFFFFFFFFFFFFE_0000000000000001,
                delay: 0, stall: 5, stray: 1'b0, mute: 1'b0};
    vecs[2] = '{a: 64'h1234, b: 64'h5678, exp: 128'h0,
                delay: 0, stall: 1, stray: 1'b0, mute: 1'b1};
    vecs[3] = '{a: 64'h1, b: 64'hDEADBEEFCAFEBABE,
                exp: 128'h0000000000000000_DEADBEEFCAFEBABE,
                delay: 3, stall: 0, stray: 1'b1, mute: 1'b0};
    vecs[4] = '{a: 64'h0000000100000000, b: 64'hFFFFFFFFFFFFFFFF,
                exp: 128'h00000000FFFFFFFF_FFFFFFFF00000000,
                delay: 5, stall: 2, stray: 1'b0, mute: 1'b0};
    vecs[5] = '{a: 64'h8000000000000000, b: 64'h2,
                exp: 128'h0000000000000001_0000000000000000,
                delay: 1, stall: 0, stray: 1'b0, mute: 1'b0};

    reset_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    @(posedge clk); #1;
    check_idle_outputs("reset");
    chk("reset_result", rsp_result, 128'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Reset while waiting on the multiplier: job dropped, no clear cycle.
    slave_delay = 5;
    slave_mute = 1'b0;
    req_a = 64'h77;
    req_b = 64'h99;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_wait", {M_sel, req_ready, rsp_valid}, 3'b000);
    wb = wr_n;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_idle_outputs("midjob_reset");
    chk("midjob_result", rsp_result, 128'h0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_idle_outputs("post_reset");
    chk("no_clr_write", wr_n - wb, 0);

    run_job(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
